// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin, burst-limited sharing of one FIFO write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wren_o,
    output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [IDX_W-1:0]   r_rr_ptr;

    logic               w_busy;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_accept;
    logic               w_release;
    logic [IDX_W-1:0]   w_next_ptr;
    logic [IDX_W-1:0]   w_start;
    logic [NUM_REQ-1:0] w_cand;
    logic               w_found;
    logic [IDX_W-1:0]   w_pick;

    assign w_busy = (r_state == ST_BURST);

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = IDX_W'(i);
            end
        end
    end

    assign w_accept   = w_busy & req_valid_i[w_gidx] & ~fifo_full_i;
    assign w_release  = w_busy & (~req_valid_i[w_gidx] |
                                  (w_accept & (r_beat_cnt == C_LAST_BEAT)));
    assign w_next_ptr = (w_gidx == C_LAST_IDX) ? '0 : w_gidx + 1'b1;

    // On release the search restarts after the outgoing requester, which is
    // masked out so a lone requester cannot be regranted on the same edge.
    assign w_start = w_release ? w_next_ptr : r_rr_ptr;
    assign w_cand  = req_valid_i & ~(w_release ? r_grant : '0);

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_cand[(int'(w_start) + i) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(w_start) + i) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_beat_cnt <= '0;
            r_rr_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state    <= ST_BURST;
                        r_grant    <= NUM_REQ'(1) << w_pick;
                        r_beat_cnt <= '0;
                    end
                end
                ST_BURST: begin
                    if (w_release) begin
                        r_rr_ptr   <= w_next_ptr;
                        r_beat_cnt <= '0;
                        if (w_found) begin
                            r_grant <= NUM_REQ'(1) << w_pick;
                        end else begin
                            r_state <= ST_IDLE;
                            r_grant <= '0;
                        end
                    end else begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(w_accept);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant_o      = r_grant;
    assign busy_o       = w_busy;
    assign fifo_wren_o  = w_accept;
    assign req_ready_o  = w_accept ? r_grant : '0;
    assign fifo_wdata_o = w_busy ? req_data_i[w_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed and randomized bench for fifo_wr_arbiter with a model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid_i;
    logic [NR*DW-1:0]  req_data_i;
    logic [NR-1:0]     req_ready_o;
    logic              fifo_full_i;
    logic              fifo_wren_o;
    logic [DW-1:0]     fifo_wdata_o;
    logic [NR-1:0]     grant_o;
    logic              busy_o;

    fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_wren_o  (fifo_wren_o),
        .fifo_wdata_o (fifo_wdata_o),
        .grant_o      (grant_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // producers: remaining words, next word value, enable
    int          left [NR];
    logic [DW-1:0] nxt [NR];
    bit          en   [NR];
    // FIFO occupancy model
    int fcnt;
    bit auto_rd;
    bit rd_once;
    // reference model: granted index (-1 idle), beats in grant, rr pointer
    int m_g, m_cnt, m_ptr;

    logic [DW-1:0] wq[$];
    int            wcyc[$];
    int            gseq[$];
    logic [NR-1:0] prev_g;
    int            cyc;

    logic [NR-1:0] s_grant, s_ready;
    logic          s_busy, s_wren;
    logic [DW-1:0] s_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic          mb, ma, rel, wr;
        logic [NR-1:0] eg, er, hs;
        logic [DW-1:0] ed;
        int            nx;
        for (int k = 0; k < NR; k++) begin
            req_valid_i[k]           = en[k] && (left[k] > 0);
            req_data_i[k*DW +: DW]   = nxt[k];
        end
        fifo_full_i = (fcnt >= DEPTH);
        #4;
        mb = (m_g >= 0);
        ma = 1'b0;
        eg = '0;
        ed = '0;
        if (mb) begin
            ma = req_valid_i[m_g] && !fifo_full_i;
            eg = NR'(1) << m_g;
            ed = nxt[m_g];
        end
        er = ma ? eg : '0;
        check("outputs", 64'({grant_o, busy_o, req_ready_o, fifo_wren_o, fifo_wdata_o}),
              64'({eg, mb, er, ma, ed}));
        check("onehot_ready_full",
              64'($onehot0(grant_o) && ((req_ready_o & ~grant_o) == '0) && !(fifo_wren_o && fifo_full_i)),
              64'(1));
        s_grant = grant_o; s_ready = req_ready_o; s_busy = busy_o;
        s_wren  = fifo_wren_o; s_wdata = fifo_wdata_o;
        if (fifo_wren_o) begin
            wq.push_back(fifo_wdata_o);
            wcyc.push_back(cyc);
        end
        if (grant_o != '0 && grant_o != prev_g) begin
            for (int k = 0; k < NR; k++) if (grant_o[k]) gseq.push_back(k);
        end
        prev_g = grant_o;
        hs = req_valid_i & req_ready_o;
        wr = fifo_wren_o;
        @(posedge clk);
        if (!rst_n) begin
            m_g = -1; m_cnt = 0; m_ptr = 0;
        end else if (m_g < 0) begin
            for (int i = 0; i < NR; i++) begin
                if (m_g < 0 && req_valid_i[(m_ptr + i) % NR]) begin
                    m_g = (m_ptr + i) % NR; m_cnt = 0;
                end
            end
        end else begin
            rel = !req_valid_i[m_g] || (ma && m_cnt == MB - 1);
            if (rel) begin
                m_ptr = (m_g + 1) % NR;
                nx = -1;
                for (int i = 1; i < NR; i++)
                    if (nx < 0 && req_valid_i[(m_g + i) % NR]) nx = (m_g + i) % NR;
                m_g = nx; m_cnt = 0;
            end else begin
                m_cnt += int'(ma);
            end
        end
        for (int k = 0; k < NR; k++) if (hs[k]) begin left[k]--; nxt[k]++; end
        if (wr) fcnt++;
        if ((auto_rd || rd_once) && fcnt > 0) fcnt--;
        rd_once = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        for (int k = 0; k < NR; k++) begin left[k] = 0; nxt[k] = '0; en[k] = 1'b1; end
        fcnt = 0; auto_rd = 1'b1; rd_once = 1'b0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        wq.delete(); wcyc.delete(); gseq.delete();
        cyc = 0;
    endtask

    task automatic check_words(input string tag, input logic [DW-1:0] exp[$]);
        check({tag, "_count"}, 64'(wq.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            check(tag, (i < wq.size()) ? 64'(wq[i]) : 64'hDEAD, 64'(exp[i]));
    endtask

    initial begin
        logic [DW-1:0] ew[$];
        m_g = -1; m_cnt = 0; m_ptr = 0; prev_g = '0; cyc = 0;
        for (int k = 0; k < NR; k++) begin left[k] = 0; nxt[k] = '0; en[k] = 1'b1; end
        req_valid_i = '0; req_data_i = '0; fifo_full_i = 1'b0; fcnt = 0;
        auto_rd = 1'b1; rd_once = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("reset_state", 64'({s_grant, s_busy, s_ready, s_wren, s_wdata}), 64'(0));

        // Reset mid-burst of req2, then fresh arbitration from req0
        left[2] = 8; nxt[2] = 8'h20;
        cycle(); cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        left[0] = 4; nxt[0] = 8'h00;
        cycle();
        check("rst_mid_idle", 64'({s_grant, s_busy, s_wren}), 64'(0));
        cycle();
        check("rst_fresh_req0", 64'(s_grant), 64'(4'b0001));

        // Lone requester: forced rotation costs one bubble
        do_reset();
        left[1] = 6; nxt[1] = 8'h10;
        repeat (10) cycle();
        ew = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        check_words("single_words", ew);
        check("single_cyc0", (wcyc.size() > 0) ? 64'(wcyc[0]) : 64'hDEAD, 64'(1));
        check("single_cyc4", (wcyc.size() > 4) ? 64'(wcyc[4]) : 64'hDEAD, 64'(6));
        check("single_gidx", (gseq.size() > 0) ? 64'(gseq[0]) : 64'hDEAD, 64'(1));

        // req0 and req2 alternate without bubbles
        do_reset();
        left[0] = 8; nxt[0] = 8'h00;
        left[2] = 4; nxt[2] = 8'h20;
        repeat (16) cycle();
        ew = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h20, 8'h21, 8'h22, 8'h23,
               8'h04, 8'h05, 8'h06, 8'h07};
        check_words("alt_words", ew);
        check("alt_last_cyc", (wcyc.size() > 11) ? 64'(wcyc[11]) : 64'hDEAD, 64'(12));

        // Full stall in the middle of a burst
        do_reset();
        auto_rd = 1'b0; fcnt = 6;
        left[0] = 8; nxt[0] = 8'h40;
        repeat (6) cycle();
        check("stall_grant", 64'({s_grant, s_busy, s_wren}), 64'({4'b0001, 1'b1, 1'b0}));
        check("stall_writes", 64'(wq.size()), 64'(2));
        rd_once = 1'b1; cycle();
        rd_once = 1'b1; cycle();
        check("resume_beat3", 64'({s_grant, s_wren, s_wdata}), 64'({4'b0001, 1'b1, 8'h42}));
        cycle();
        check("resume_beat4", 64'({s_grant, s_wren, s_wdata}), 64'({4'b0001, 1'b1, 8'h43}));
        cycle();
        check("stall_release", 64'(s_grant), 64'(0));
        auto_rd = 1'b1;

        // req3 drops valid after two beats while req0 waits
        do_reset();
        left[3] = 2; nxt[3] = 8'h30;
        cycle();
        left[0] = 4; nxt[0] = 8'h00;
        cycle(); cycle(); cycle();
        check("drop_hold", 64'({s_grant, s_ready}), 64'({4'b1000, 4'b0000}));
        cycle();
        check("drop_regrant", 64'(s_grant), 64'(4'b0001));

        // All four requesters: full rotation
        do_reset();
        for (int k = 0; k < NR; k++) begin left[k] = 4; nxt[k] = DW'(k * 16); end
        left[0] = 8;
        repeat (24) cycle();
        check("rot_count", 64'(gseq.size()), 64'(5));
        for (int i = 0; i < 5; i++)
            check("rot_seq", (i < gseq.size()) ? 64'(gseq[i]) : 64'hDEAD, 64'(i % NR));

        // Randomized traffic against the model
        do_reset();
        repeat (400) begin
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(7) == 0) en[k] = !en[k];
                if (left[k] == 0 && $urandom_range(3) == 0) left[k] = int'($urandom_range(9, 1));
            end
            auto_rd = ($urandom_range(1) == 1);
            rst_n   = ($urandom_range(63) != 0);
            cycle();
        end
        rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
